// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU control: combinational ALU select decode, plus an iterative
// unsigned multiply/divide sequencer that owns the HI/LO registers and stalls the pipeline.
module alu_mdu_ctrl #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic [WIDTH-1:0]  src_a_i,
    input  logic [WIDTH-1:0]  src_b_i,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              illegal_o,
    output logic              stall_o,
    output logic              md_done_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);

    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0] acc_lo_reg, acc_lo_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;

    logic [3:0] sel;
    logic       is_md;
    logic       unknown_funct;
    logic       md_req;
    logic       last_iter;

    // ---------------- combinational decode ----------------
    always_comb begin
        sel           = 4'b0000;
        is_md         = 1'b0;
        unknown_funct = 1'b0;
        case (aluop_i)
            2'b00: begin
                case (funct_i)
                    6'b100011:            sel = 4'b0000;
                    6'b100001:            sel = 4'b0001;
                    6'b100110:            sel = 4'b0010;
                    6'b100101:            sel = 4'b0011;
                    6'b101011:            sel = 4'b0100;
                    6'b101000:            sel = 4'b0101;
                    FUNCT_MULT, FUNCT_DIV: begin
                        sel   = 4'b1111;
                        is_md = 1'b1;
                    end
                    default: begin
                        sel           = 4'b1111;
                        unknown_funct = 1'b1;
                    end
                endcase
            end
            2'b01:   sel = 4'b0000;
            default: sel = 4'b0001;
        endcase
    end

    assign alu_ctrl_o = CTRL_W'(sel);
    assign illegal_o  = valid_i & unknown_funct;
    assign md_req     = valid_i & is_md;
    assign last_iter  = (cnt_reg == CNT_W'(WIDTH - 1));

    // ---------------- one iteration of each algorithm ----------------
    // Multiply: {acc_hi, acc_lo} is the partial product, acc_lo initially the multiplier.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_step, mul_lo_step;
    assign mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
    assign mul_hi_step = mul_sum[WIDTH:1];
    assign mul_lo_step = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_step, div_lo_step;
    assign div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opb_reg};
    assign div_ge      = ~div_diff[WIDTH];
    assign div_hi_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_step = {acc_lo_reg[WIDTH-2:0], div_ge};

    // ---------------- sequencer ----------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        opb_next    = opb_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        stall_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (md_req && !flush_i) begin
                    stall_o  = 1'b1;
                    cnt_next = '0;
                    if (funct_i == FUNCT_DIV) begin
                        if (src_b_i == '0) begin
                            hi_next    = src_a_i;
                            lo_next    = {WIDTH{1'b1}};
                            state_next = DONE;
                        end else begin
                            acc_hi_next = '0;
                            acc_lo_next = src_a_i;
                            opb_next    = src_b_i;
                            state_next  = DIV;
                        end
                    end else begin
                        acc_hi_next = '0;
                        acc_lo_next = src_b_i;
                        opb_next    = src_a_i;
                        state_next  = MUL;
                    end
                end
            end
            MUL: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    stall_o     = 1'b1;
                    acc_hi_next = mul_hi_step;
                    acc_lo_next = mul_lo_step;
                    cnt_next    = cnt_reg + 1'b1;
                    if (last_iter) begin
                        hi_next    = mul_hi_step;
                        lo_next    = mul_lo_step;
                        state_next = DONE;
                    end
                end
            end
            DIV: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    stall_o     = 1'b1;
                    acc_hi_next = div_hi_step;
                    acc_lo_next = div_lo_step;
                    cnt_next    = cnt_reg + 1'b1;
                    if (last_iter) begin
                        hi_next    = div_hi_step;
                        lo_next    = div_lo_step;
                        state_next = DONE;
                    end
                end
            end
            // Result was committed on the edge into this state; just release the pipeline.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opb_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            opb_reg    <= opb_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign md_done_o = (state_reg == DONE);
    assign hi_o      = hi_reg;
    assign lo_o      = lo_reg;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl: directed decode/latency/flush/reset cases plus
// randomized mult/div checked against plain-arithmetic reference results.
module tb_alu_mdu_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 32-bit instance
    logic        valid, flush;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic [3:0]  ctrl;
    logic        illegal, stall, done;
    logic [31:0] hi, lo;

    // 8-bit instance
    logic        valid8, flush8;
    logic [1:0]  aluop8;
    logic [5:0]  funct8;
    logic [7:0]  src_a8, src_b8;
    logic [3:0]  ctrl8;
    logic        illegal8, stall8, done8;
    logic [7:0]  hi8, lo8;

    alu_mdu_ctrl #(.WIDTH(32), .CTRL_W(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
        .aluop_i(aluop), .funct_i(funct), .src_a_i(src_a), .src_b_i(src_b),
        .alu_ctrl_o(ctrl), .illegal_o(illegal), .stall_o(stall),
        .md_done_o(done), .hi_o(hi), .lo_o(lo)
    );

    alu_mdu_ctrl #(.WIDTH(8), .CTRL_W(4)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid8), .flush_i(flush8),
        .aluop_i(aluop8), .funct_i(funct8), .src_a_i(src_a8), .src_b_i(src_b8),
        .alu_ctrl_o(ctrl8), .illegal_o(illegal8), .stall_o(stall8),
        .md_done_o(done8), .hi_o(hi8), .lo_o(lo8)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_hi [2];
    logic [31:0] last_lo [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode table for the ALU select.
    function automatic void ref_decode(input logic v, input logic [1:0] op, input logic [5:0] fn,
                                       output logic [3:0] c, output logic il);
        il = 1'b0;
        c  = 4'h0;
        if (op == 2'b01)      c = 4'h0;
        else if (op != 2'b00) c = 4'h1;
        else begin
            case (fn)
                6'b100011: c = 4'h0;
                6'b100001: c = 4'h1;
                6'b100110: c = 4'h2;
                6'b100101: c = 4'h3;
                6'b101011: c = 4'h4;
                6'b101000: c = 4'h5;
                6'b011000, 6'b011010: c = 4'hF;
                default: begin c = 4'hF; il = v; end
            endcase
        end
    endfunction

    // Reference mult/div result and expected number of stalled cycles.
    function automatic void ref_md(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                   input bit is_div, output logic [31:0] eh, output logic [31:0] el,
                                   output int stalls);
        logic [63:0] mask, a, b, prod;
        mask = (64'd1 << w) - 1;
        a = {32'd0, a_in} & mask;
        b = {32'd0, b_in} & mask;
        if (is_div) begin
            if (b == 0) begin
                eh = a[31:0]; el = mask[31:0]; stalls = 1;
            end else begin
                eh = 32'(a % b); el = 32'(a / b); stalls = w + 1;
            end
        end else begin
            prod = a * b;
            eh = 32'((prod >> w) & mask);
            el = 32'(prod & mask);
            stalls = w + 1;
        end
    endfunction

    task automatic drive(input bit use8, input logic v, input logic f, input logic [1:0] op,
                         input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        if (use8) begin
            valid8 = v; flush8 = f; aluop8 = op; funct8 = fn; src_a8 = a[7:0]; src_b8 = b[7:0];
        end else begin
            valid = v; flush = f; aluop = op; funct = fn; src_a = a; src_b = b;
        end
    endtask

    task automatic sample(input bit use8, output logic s, output logic d,
                          output logic [31:0] h, output logic [31:0] l);
        if (use8) begin s = stall8; d = done8; h = {24'd0, hi8}; l = {24'd0, lo8}; end
        else      begin s = stall;  d = done;  h = hi;            l = lo;            end
    endtask

    // Issue one mult/div, hold it while stalled, then check latency, pulse and result.
    task automatic run_md(input bit use8, input logic [31:0] a, input logic [31:0] b,
                          input bit is_div, input string tag);
        int w, exp_stalls, n, hold_bad;
        bit seen;
        logic [31:0] eh, el, h, l;
        logic s, d;
        w = use8 ? 8 : 32;
        ref_md(w, a, b, is_div, eh, el, exp_stalls);
        n = 0; hold_bad = 0; seen = 0;
        @(posedge clk); #1;
        drive(use8, 1'b1, 1'b0, 2'b00, is_div ? 6'b011010 : 6'b011000, a, b);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            sample(use8, s, d, h, l);
            if (d) begin seen = 1; break; end
            if (s) n++;
            if (h !== last_hi[use8] || l !== last_lo[use8]) hold_bad++;
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_stall_cnt"}, 64'(n), 64'(exp_stalls));
        chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
        chk({tag, "_stall_done"}, 64'(s), 64'd0);
        chk({tag, "_hi"}, 64'(h), 64'(eh));
        chk({tag, "_lo"}, 64'(l), 64'(el));
        $display("md %s w=%0d a=%0h b=%0h div=%0d -> hi=%0h lo=%0h stalls=%0d",
                 tag, w, a, b, is_div, h, l, n);
        last_hi[use8] = eh;
        last_lo[use8] = el;
        @(posedge clk); #1;
        drive(use8, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        @(negedge clk);
        sample(use8, s, d, h, l);
        chk({tag, "_pulse1"}, 64'(d), 64'd0);
    endtask

    logic [5:0]  fn_tab [6];
    logic [3:0]  ec;
    logic        eil;
    logic [31:0] ra, rb;
    logic        s0, d0;
    logic [31:0] h0, l0;

    initial begin
        fn_tab[0] = 6'b100011; fn_tab[1] = 6'b100001; fn_tab[2] = 6'b100110;
        fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101011; fn_tab[5] = 6'b101000;
        last_hi[0] = 0; last_lo[0] = 0; last_hi[1] = 0; last_lo[1] = 0;
        rst = 1'b1;
        drive(0, 0, 0, 2'b00, 6'd0, 32'd0, 32'd0);
        drive(1, 0, 0, 2'b00, 6'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", 64'(hi), 0);   chk("rst_lo", 64'(lo), 0);
        chk("rst_done", 64'(done), 0); chk("rst_stall", 64'(stall), 0);
        chk("rst_hi8", 64'(hi8), 0); chk("rst_done8", 64'(done8), 0);
        rst = 1'b0;

        // Directed decode sweep (flush held so mult/div functs never start)
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(0, 1, 1, 2'b00, fn_tab[i], 32'd0, 32'd0);
            #1;
            chk($sformatf("dec_rtype%0d", i), 64'(ctrl), 64'(i));
            chk($sformatf("dec_rtype%0d_ill", i), 64'(illegal), 0);
        end
        for (int op = 1; op < 4; op++) begin
            @(posedge clk); #1;
            drive(0, 1, 1, 2'(op), 6'b111111, 32'd0, 32'd0);
            #1;
            chk($sformatf("dec_aluop%0d", op), 64'(ctrl), (op == 1) ? 64'd0 : 64'd1);
            chk($sformatf("dec_aluop%0d_ill", op), 64'(illegal), 0);
        end
        @(posedge clk); #1;
        drive(0, 1, 0, 2'b00, 6'b111111, 32'd0, 32'd0); #1;
        chk("dec_illegal_ctrl", 64'(ctrl), 64'hF);
        chk("dec_illegal", 64'(illegal), 1);
        chk("dec_illegal_stall", 64'(stall), 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 2'b00, 6'b111111, 32'd0, 32'd0); #1;
        chk("dec_illegal_novalid", 64'(illegal), 0);
        @(posedge clk); #1;
        drive(0, 1, 1, 2'b00, 6'b011000, 32'd5, 32'd6); #1;
        chk("dec_mult_ctrl", 64'(ctrl), 64'hF);
        chk("dec_mult_ill", 64'(illegal), 0);
        chk("flush_idle_stall", 64'(stall), 0);
        @(posedge clk); #1;
        chk("flush_idle_nodone", 64'(done), 0);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            drive(0, 1'($urandom), 1'b1, 2'($urandom), (i % 2 == 0) ? fn_tab[$urandom_range(0, 5)] : 6'($urandom),
                  32'd0, 32'd0);
            #1;
            ref_decode(valid, aluop, funct, ec, eil);
            chk($sformatf("dec_rand%0d", i), 64'(ctrl), 64'(ec));
            chk($sformatf("dec_rand%0d_ill", i), 64'(illegal), 64'(eil));
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 2'b00, 6'd0, 32'd0, 32'd0);

        // Directed mult/div cases
        run_md(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mult_max");
        run_md(0, 32'd100, 32'd7, 1, "div_100_7");
        run_md(0, 32'h1234, 32'd0, 1, "div_zero");

        // Flush in the middle of a mult
        @(posedge clk); #1;
        drive(0, 1, 0, 2'b00, 6'b011000, 32'hDEAD_BEEF, 32'h1357_9BDF);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; #1;
        chk("flush_mul_stall", 64'(stall), 0);
        chk("flush_mul_done", 64'(done), 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 2'b00, 6'd0, 32'd0, 32'd0);
        s0 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) s0 = 1;
        end
        chk("flush_no_done", 64'(s0), 0);
        chk("flush_hi_kept", 64'(hi), 64'(last_hi[0]));
        chk("flush_lo_kept", 64'(lo), 64'(last_lo[0]));
        run_md(0, 32'd3, 32'd5, 0, "mult_3_5");

        // Randomized mult/div against the reference model
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_md(0, ra, rb, (i % 2 == 1) || (i == 4), $sformatf("rnd32_%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run_md(1, ra, rb, i[0] || (i == 3), $sformatf("rnd8_%0d", i));
        end
        run_md(1, 32'd77, 32'd201, 0, "mult8_77_201");

        // Asynchronous reset in the middle of a div
        @(posedge clk); #1;
        drive(0, 1, 0, 2'b00, 6'b011010, 32'hFFFF_0000, 32'd9);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        drive(0, 0, 0, 2'b00, 6'd0, 32'd0, 32'd0);
        #1;
        chk("arst_hi", 64'(hi), 0);
        chk("arst_lo", 64'(lo), 0);
        chk("arst_done", 64'(done), 0);
        chk("arst_stall", 64'(stall), 0);
        chk("arst_hi8", 64'(hi8), 0);
        chk("arst_lo8", 64'(lo8), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_hi[0] = 0; last_lo[0] = 0; last_hi[1] = 0; last_lo[1] = 0;
        @(negedge clk);
        sample(0, s0, d0, h0, l0);
        chk("arst_idle_done", 64'(d0), 0);
        chk("arst_idle_hi", 64'(h0), 0);
        run_md(1, 32'd200, 32'd3, 1, "div8_200_3");
        run_md(0, 32'd200, 32'd3, 1, "div32_200_3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
- Parametrised ALU control unit for the EX stage of the single-issue pipeline.
- Decodes ALUOp/funct into the 4-bit ALU select for single-cycle operations.
- Adds an iterative multiply/divide sequencer for the new mult/div R-type functs, writing the HI/LO registers.
- Drives stall_o to hold the pipeline while a multi-cycle operation runs.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits
CTRL_W, 4, width of the ALU select output
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  EX stage holds a valid instruction this cycle
flush_i  in  1  abort any in-flight mult/div (branch/exception flush)
aluop_i  in  2  00 R-type, 01 lw/sw/addi, 10 beq, 11 bne
funct_i  in  6  R-type function field
src_a_i  in  WIDTH  multiplicand / dividend
src_b_i  in  WIDTH  multiplier / divisor
alu_ctrl_o  out  CTRL_W  ALU select (combinational)
illegal_o  out  1  unknown R-type funct with valid_i (combinational)
stall_o  out  1  hold IF/ID/EX registers
md_done_o  out  1  one-cycle pulse: HI/LO just updated
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset state: state=IDLE, hi_o=0, lo_o=0, md_done_o=0, counter=0, internal accumulators=0.
- Combinational decode, identical in every state:
  - aluop 00 with funct: 100011→0000 add; 100001→0001 sub; 100110→0010 and; 100101→0011 or; 101011→0100 nor; 101000→0101 slt.
  - aluop 00 with funct 011000 (mult) or 011010 (div): alu_ctrl_o=1111.
  - aluop 01→0000; aluop 10/11→0001.
  - Any other funct under aluop 00: alu_ctrl_o=1111, illegal_o=valid_i.
- md_req = valid_i & aluop_i==00 & funct is mult or div.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: if md_req and !flush_i, latch operands, counter=0, go to MUL or DIV. If div with src_b_i==0, go directly to DONE with result hi=src_a_i, lo={WIDTH{1}}.
  - MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles, then DONE.
  - DIV: unsigned restoring division, one quotient bit per cycle, WIDTH cycles, then DONE.
  - DONE: commit result (mult: hi=product[2W-1:W], lo=product[W-1:0]; div: hi=remainder, lo=quotient). Assert md_done_o for this cycle only, then go to IDLE.
  - hi_o/lo_o are registered and change only on the clock edge entering DONE.
- stall_o:
  - 1 in the IDLE cycle where md_req & !flush_i.
  - 1 throughout MUL/DIV.
  - 0 in DONE, so the pipeline advances one cycle after md_done_o rises.
  - Total: mult/div occupies EX for WIDTH+1 stalled cycles plus the DONE cycle. Div-by-zero: 1 stalled cycle plus DONE.
- New requests are accepted only in IDLE. Inputs presented in DONE are ignored; the pipeline re-presents them in IDLE.
- flush_i:
  - In MUL/DIV: go to IDLE next edge; hi/lo unchanged; no md_done_o; stall_o=0 in the flush cycle.
  - In IDLE: suppresses acceptance.
  - In DONE: the commit still occurs.
- rst_i asserted mid-operation: immediate return to reset state; partial result discarded.
- Counter saturates only via the FSM exit at count==WIDTH-1; no wrap-around is observable.

Test Plan:
- Decode sweep: aluop 00 with each of the 6 functs → 0000..0101; aluop 01/10/11 → 0000/0001/0001; funct 111111 with valid_i → 1111, illegal_o=1.
- WIDTH=32 mult: 0xFFFFFFFF×0xFFFFFFFF → after 33 stall cycles, md_done_o pulse; hi=0xFFFFFFFE, lo=0x00000001; stall_o low in the done cycle.
- div: 100/7 → hi=2, lo=14, same latency; check stall_o count exactly WIDTH+1.
- div by zero: 0x1234/0 → 1 stall cycle then done; hi=0x1234, lo=0xFFFFFFFF.
- flush_i at cycle 10 of a mult → IDLE next edge; hi/lo keep prior values; no md_done_o; a subsequent mult 3×5 gives hi=0, lo=15.
- rst_i pulsed asynchronously mid-div → all outputs 0 immediately; WIDTH=8 rerun of 200/3 gives hi=2, lo=66 after 9 stall cycles.
